// File: rtl/router_out_arbiter.sv
// Per-output-port round-robin arbiter for the serial router: owns one output lane per packet,
// drives input back-pressure, and adds a packet watchdog plus a forced inter-packet gap.
module router_out_arbiter #(
  parameter int unsigned NUM_IN         = 16,
  parameter int unsigned MAX_PKT_CYCLES = 1024,
  parameter int unsigned GAP_CYCLES     = 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_IN-1:0]         req,
  input  logic                      pkt_done,
  output logic [NUM_IN-1:0]         grant,
  output logic [$clog2(NUM_IN)-1:0] grant_id,
  output logic                      grant_valid,
  output logic [NUM_IN-1:0]         busy_n,
  output logic                      timeout_err,
  output logic [15:0]               pkt_count
);

  localparam int unsigned IdW  = $clog2(NUM_IN);
  localparam int unsigned WdW  = $clog2(MAX_PKT_CYCLES + 1);
  localparam int unsigned GapW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StActive, StGap} state_e;

  state_e            state_q, state_d;
  logic [IdW-1:0]    grant_id_q, grant_id_d;
  logic              grant_valid_q, grant_valid_d;
  logic [IdW-1:0]    last_winner_q, last_winner_d;
  logic [WdW-1:0]    wd_cnt_q, wd_cnt_d;
  logic [GapW-1:0]   gap_cnt_q, gap_cnt_d;
  logic [15:0]       pkt_count_q, pkt_count_d;
  logic              timeout_q, timeout_d;

  logic              win_found;
  logic [IdW-1:0]    win_id;
  int unsigned       idx;
  logic              take_grant;
  logic              end_pkt;

  // Round-robin search starting just above the previous winner.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    for (int unsigned k = 1; k <= NUM_IN; k++) begin
      idx = (int'(last_winner_q) + k) % NUM_IN;
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_id    = IdW'(idx);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_id_d    = grant_id_q;
    grant_valid_d = grant_valid_q;
    last_winner_d = last_winner_q;
    wd_cnt_d      = wd_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    pkt_count_d   = pkt_count_q;
    timeout_d     = 1'b0;
    take_grant    = 1'b0;
    end_pkt       = 1'b0;

    unique case (state_q)
      StIdle: begin
        take_grant = win_found;
      end
      StActive: begin
        if (pkt_done) begin
          pkt_count_d = pkt_count_q + 16'd1;
          end_pkt     = 1'b1;
        end else if (!req[grant_id_q]) begin
          end_pkt = 1'b1;
        end else if (wd_cnt_q == WdW'(MAX_PKT_CYCLES - 1)) begin
          timeout_d = 1'b1;
          end_pkt   = 1'b1;
        end else begin
          wd_cnt_d = wd_cnt_q + WdW'(1);
        end
      end
      StGap: begin
        // The last gap clock arbitrates directly so the lane idles exactly GAP_CYCLES clocks.
        if (gap_cnt_q == GapW'(GAP_CYCLES - 1)) begin
          if (win_found) begin
            take_grant = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + GapW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    if (end_pkt) begin
      state_d       = StGap;
      grant_valid_d = 1'b0;
      grant_id_d    = '0;
      gap_cnt_d     = '0;
    end

    if (take_grant) begin
      state_d       = StActive;
      grant_valid_d = 1'b1;
      grant_id_d    = win_id;
      last_winner_d = win_id;
      wd_cnt_d      = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= StIdle;
      grant_id_q    <= '0;
      grant_valid_q <= 1'b0;
      last_winner_q <= IdW'(NUM_IN - 1);
      wd_cnt_q      <= '0;
      gap_cnt_q     <= '0;
      pkt_count_q   <= '0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_id_q    <= grant_id_d;
      grant_valid_q <= grant_valid_d;
      last_winner_q <= last_winner_d;
      wd_cnt_q      <= wd_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      pkt_count_q   <= pkt_count_d;
      timeout_q     <= timeout_d;
    end
  end

  always_comb begin
    grant = '0;
    if (grant_valid_q) begin
      grant[grant_id_q] = 1'b1;
    end
  end

  // The current owner never sees back-pressure; idle lanes push back on nobody.
  always_comb begin
    busy_n = '1;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (state_q != StIdle && req[i] &&
          !(state_q == StActive && grant_id_q == IdW'(i))) begin
        busy_n[i] = 1'b0;
      end
    end
  end

  assign grant_id    = grant_id_q;
  assign grant_valid = grant_valid_q;
  assign timeout_err = timeout_q;
  assign pkt_count   = pkt_count_q;

endmodule
